// File: rtl/apb_xfer_sched.sv
// Single-outstanding scheduler: round-robin read/write requests onto one APB master, two slave windows.
// Optional ACCESS-phase abort counter enabled with `define APB_TIMEOUT_EN.
module apb_xfer_sched #(
  parameter int                   WIDTH_PAD     = 32,
  parameter int                   WIDTH_PDA     = 32,
  parameter logic [WIDTH_PAD-1:0] ADDR_PBASE0   = 32'hC0000000,
  parameter int                   ADDR_PLENGTH0 = 16,
  parameter logic [WIDTH_PAD-1:0] ADDR_PBASE1   = 32'hC0001000,
  parameter int                   ADDR_PLENGTH1 = 16,
  parameter int                   TIMEOUT_CYC   = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   WREQ_VALID,
  output logic                   WREQ_READY,
  input  logic [WIDTH_PAD-1:0]   WREQ_ADDR,
  input  logic [WIDTH_PDA-1:0]   WREQ_DATA,
  input  logic [WIDTH_PDA/8-1:0] WREQ_STRB,
  output logic                   WRSP_VALID,
  input  logic                   WRSP_READY,
  output logic                   WRSP_ERR,
  input  logic                   RREQ_VALID,
  output logic                   RREQ_READY,
  input  logic [WIDTH_PAD-1:0]   RREQ_ADDR,
  output logic                   RRSP_VALID,
  input  logic                   RRSP_READY,
  output logic [WIDTH_PDA-1:0]   RRSP_DATA,
  output logic                   RRSP_ERR,
  output logic [WIDTH_PAD-1:0]   M_PADDR,
  output logic                   M_PWRITE,
  output logic [WIDTH_PDA-1:0]   M_PWDATA,
  output logic [WIDTH_PDA/8-1:0] M_PSTRB,
  output logic                   M_PENABLE,
  output logic                   M0_PSEL,
  input  logic [WIDTH_PDA-1:0]   M0_PRDATA,
  input  logic                   M0_PREADY,
  input  logic                   M0_PSLVERR,
  output logic                   M1_PSEL,
  input  logic [WIDTH_PDA-1:0]   M1_PRDATA,
  input  logic                   M1_PREADY,
  input  logic                   M1_PSLVERR
);

  localparam logic [WIDTH_PAD-1:0] MASK0 =
    ~((WIDTH_PAD'(1) << ADDR_PLENGTH0) - WIDTH_PAD'(1));
  localparam logic [WIDTH_PAD-1:0] MASK1 =
    ~((WIDTH_PAD'(1) << ADDR_PLENGTH1) - WIDTH_PAD'(1));

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                 state_q;
  logic                   prio_rd_q;
  logic                   dir_wr_q;
  logic                   sel1_q;
  logic [WIDTH_PAD-1:0]   paddr_q;
  logic                   pwrite_q;
  logic [WIDTH_PDA-1:0]   pwdata_q;
  logic [WIDTH_PDA/8-1:0] pstrb_q;
  logic                   penable_q;
  logic                   psel0_q;
  logic                   psel1_q;
  logic                   wrsp_valid_q;
  logic                   wrsp_err_q;
  logic                   rrsp_valid_q;
  logic                   rrsp_err_q;
  logic [WIDTH_PDA-1:0]   rrsp_data_q;

  logic                   wr_sel;
  logic                   rd_sel;
  logic [WIDTH_PAD-1:0]   req_addr;
  logic                   hit0;
  logic                   hit1;
  logic                   pready_sel;
  logic                   pslverr_sel;
  logic [WIDTH_PDA-1:0]   prdata_sel;
  logic                   tmo_hit;
  logic                   acc_done;
  logic                   acc_err;
  logic [WIDTH_PDA-1:0]   acc_data;
  logic                   rsp_taken;

  // Priority pointer only matters when both sides are valid at once.
  assign wr_sel = WREQ_VALID & (~RREQ_VALID | ~prio_rd_q);
  assign rd_sel = RREQ_VALID & (~WREQ_VALID |  prio_rd_q);

  assign WREQ_READY = (state_q == S_IDLE) & wr_sel;
  assign RREQ_READY = (state_q == S_IDLE) & rd_sel;

  assign req_addr = wr_sel ? WREQ_ADDR : RREQ_ADDR;
  assign hit0     = (req_addr & MASK0) == ADDR_PBASE0;
  assign hit1     = (req_addr & MASK1) == ADDR_PBASE1;

  assign pready_sel  = sel1_q ? M1_PREADY  : M0_PREADY;
  assign pslverr_sel = sel1_q ? M1_PSLVERR : M0_PSLVERR;
  assign prdata_sel  = sel1_q ? M1_PRDATA  : M0_PRDATA;

`ifdef APB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] tmo_cnt_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_ACCESS) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  // Fires on the last allowed ACCESS cycle; a PREADY in that cycle still wins.
  assign tmo_hit = (state_q == S_ACCESS) & ~pready_sel &
                   (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  assign acc_done  = pready_sel | tmo_hit;
  assign acc_err   = pready_sel ? pslverr_sel : 1'b1;
  assign acc_data  = pready_sel ? prdata_sel : '0;
  assign rsp_taken = dir_wr_q ? WRSP_READY : RRSP_READY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      prio_rd_q    <= 1'b0;
      dir_wr_q     <= 1'b0;
      sel1_q       <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      penable_q    <= 1'b0;
      psel0_q      <= 1'b0;
      psel1_q      <= 1'b0;
      wrsp_valid_q <= 1'b0;
      wrsp_err_q   <= 1'b0;
      rrsp_valid_q <= 1'b0;
      rrsp_err_q   <= 1'b0;
      rrsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_sel | rd_sel) begin
            prio_rd_q <= wr_sel;
            dir_wr_q  <= wr_sel;
            if (hit0 | hit1) begin
              sel1_q   <= ~hit0;
              psel0_q  <= hit0;
              psel1_q  <= ~hit0;
              paddr_q  <= req_addr;
              pwrite_q <= wr_sel;
              pwdata_q <= wr_sel ? WREQ_DATA : '0;
              pstrb_q  <= wr_sel ? WREQ_STRB : '0;
              state_q  <= S_SETUP;
            end else begin
              // Decode miss: answer directly, the APB bus never moves.
              wrsp_valid_q <= wr_sel;
              wrsp_err_q   <= wr_sel;
              rrsp_valid_q <= rd_sel;
              rrsp_err_q   <= rd_sel;
              if (rd_sel) rrsp_data_q <= '0;
              state_q <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (acc_done) begin
            psel0_q   <= 1'b0;
            psel1_q   <= 1'b0;
            penable_q <= 1'b0;
            if (dir_wr_q) begin
              wrsp_valid_q <= 1'b1;
              wrsp_err_q   <= acc_err;
            end else begin
              rrsp_valid_q <= 1'b1;
              rrsp_err_q   <= acc_err;
              rrsp_data_q  <= acc_data;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_taken) begin
            wrsp_valid_q <= 1'b0;
            rrsp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign M_PADDR    = paddr_q;
  assign M_PWRITE   = pwrite_q;
  assign M_PWDATA   = pwdata_q;
  assign M_PSTRB    = pstrb_q;
  assign M_PENABLE  = penable_q;
  assign M0_PSEL    = psel0_q;
  assign M1_PSEL    = psel1_q;
  assign WRSP_VALID = wrsp_valid_q;
  assign WRSP_ERR   = wrsp_err_q;
  assign RRSP_VALID = rrsp_valid_q;
  assign RRSP_ERR   = rrsp_err_q;
  assign RRSP_DATA  = rrsp_data_q;

endmodule

// File: tb/tb_apb_xfer_sched.sv
// Directed bench for apb_xfer_sched; windows narrowed to 4 KiB so the two slaves do not overlap.
module tb_apb_xfer_sched;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        WREQ_VALID, WREQ_READY;
  logic [31:0] WREQ_ADDR, WREQ_DATA;
  logic [3:0]  WREQ_STRB;
  logic        WRSP_VALID, WRSP_READY, WRSP_ERR;
  logic        RREQ_VALID, RREQ_READY;
  logic [31:0] RREQ_ADDR;
  logic        RRSP_VALID, RRSP_READY, RRSP_ERR;
  logic [31:0] RRSP_DATA;
  logic [31:0] M_PADDR, M_PWDATA;
  logic        M_PWRITE, M_PENABLE;
  logic [3:0]  M_PSTRB;
  logic        M0_PSEL, M0_PREADY, M0_PSLVERR;
  logic [31:0] M0_PRDATA;
  logic        M1_PSEL, M1_PREADY, M1_PSLVERR;
  logic [31:0] M1_PRDATA;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  apb_xfer_sched #(
    .WIDTH_PAD    (32),
    .WIDTH_PDA    (32),
    .ADDR_PBASE0  (32'hC0000000),
    .ADDR_PLENGTH0(12),
    .ADDR_PBASE1  (32'hC0001000),
    .ADDR_PLENGTH1(12),
    .TIMEOUT_CYC  (8)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .WREQ_VALID(WREQ_VALID),
    .WREQ_READY(WREQ_READY),
    .WREQ_ADDR (WREQ_ADDR),
    .WREQ_DATA (WREQ_DATA),
    .WREQ_STRB (WREQ_STRB),
    .WRSP_VALID(WRSP_VALID),
    .WRSP_READY(WRSP_READY),
    .WRSP_ERR  (WRSP_ERR),
    .RREQ_VALID(RREQ_VALID),
    .RREQ_READY(RREQ_READY),
    .RREQ_ADDR (RREQ_ADDR),
    .RRSP_VALID(RRSP_VALID),
    .RRSP_READY(RRSP_READY),
    .RRSP_DATA (RRSP_DATA),
    .RRSP_ERR  (RRSP_ERR),
    .M_PADDR   (M_PADDR),
    .M_PWRITE  (M_PWRITE),
    .M_PWDATA  (M_PWDATA),
    .M_PSTRB   (M_PSTRB),
    .M_PENABLE (M_PENABLE),
    .M0_PSEL   (M0_PSEL),
    .M0_PRDATA (M0_PRDATA),
    .M0_PREADY (M0_PREADY),
    .M0_PSLVERR(M0_PSLVERR),
    .M1_PSEL   (M1_PSEL),
    .M1_PRDATA (M1_PRDATA),
    .M1_PREADY (M1_PREADY),
    .M1_PSLVERR(M1_PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b0;
    WREQ_VALID = 0; WREQ_ADDR = 0; WREQ_DATA = 0; WREQ_STRB = 0;
    RREQ_VALID = 0; RREQ_ADDR = 0;
    WRSP_READY = 1; RRSP_READY = 1;
    M0_PREADY = 1; M0_PSLVERR = 0; M0_PRDATA = 0;
    M1_PREADY = 0; M1_PSLVERR = 0; M1_PRDATA = 0;
    #2 ARESET = 1'b1;
    repeat (3) nxt();
    #1;
    chk("rst_psel0",   M0_PSEL, 0);
    chk("rst_psel1",   M1_PSEL, 0);
    chk("rst_penable", M_PENABLE, 0);
    chk("rst_pwrite",  M_PWRITE, 0);
    chk("rst_paddr",   M_PADDR, 0);
    chk("rst_pwdata",  M_PWDATA, 0);
    chk("rst_pstrb",   M_PSTRB, 0);
    chk("rst_wrsp_v",  WRSP_VALID, 0);
    chk("rst_rrsp_v",  RRSP_VALID, 0);
    chk("rst_errs",    {WRSP_ERR, RRSP_ERR}, 0);
    chk("rst_rdata",   RRSP_DATA, 0);
    nxt(); ARESET = 1'b0;

    // Zero-wait write to slave 0
    nxt(); WREQ_VALID = 1; WREQ_ADDR = 32'hC000_0010; WREQ_DATA = 32'hA5A5_0001; WREQ_STRB = 4'hF;
    #1; chk("w1_wready", WREQ_READY, 1); chk("w1_rready", RREQ_READY, 0); chk("w1_c0_psel", M0_PSEL, 0);
    nxt(); WREQ_VALID = 0;
    #1; chk("w1_c1_psel", M0_PSEL, 1); chk("w1_c1_pen", M_PENABLE, 0);
    chk("w1_paddr", M_PADDR, 32'hC000_0010); chk("w1_pwdata", M_PWDATA, 32'hA5A5_0001);
    chk("w1_pstrb", M_PSTRB, 4'hF); chk("w1_pwrite", M_PWRITE, 1); chk("w1_c1_wrsp", WRSP_VALID, 0);
    nxt(); #1; chk("w1_c2_psel", M0_PSEL, 1); chk("w1_c2_pen", M_PENABLE, 1); chk("w1_c2_psel1", M1_PSEL, 0);
    nxt(); #1; chk("w1_c3_psel", M0_PSEL, 0); chk("w1_c3_pen", M_PENABLE, 0);
    chk("w1_c3_wrsp", WRSP_VALID, 1); chk("w1_c3_err", WRSP_ERR, 0);
    nxt(); #1; chk("w1_c4_wrsp", WRSP_VALID, 0); chk("w1_hold_paddr", M_PADDR, 32'hC000_0010);

    // Read from slave 1 with 3 wait states; slave 0 lines must be ignored
    nxt(); RREQ_VALID = 1; RREQ_ADDR = 32'hC000_1004; M0_PSLVERR = 1;
    #1; chk("r2_rready", RREQ_READY, 1);
    nxt(); RREQ_VALID = 0;
    #1; chk("r2_setup_psel1", M1_PSEL, 1); chk("r2_setup_pen", M_PENABLE, 0); chk("r2_psel0", M0_PSEL, 0);
    chk("r2_pwrite", M_PWRITE, 0); chk("r2_pstrb", M_PSTRB, 0); chk("r2_pwdata", M_PWDATA, 0);
    chk("r2_paddr", M_PADDR, 32'hC000_1004);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1; chk("r2_wait_pen", M_PENABLE, 1); chk("r2_wait_psel1", M1_PSEL, 1);
      chk("r2_wait_psel0", M0_PSEL, 0); chk("r2_wait_rrsp", RRSP_VALID, 0);
    end
    nxt(); M1_PREADY = 1; M1_PRDATA = 32'h1234_5678;
    #1; chk("r2_acc4_pen", M_PENABLE, 1);
    nxt(); M1_PREADY = 0;
    #1; chk("r2_rrsp", RRSP_VALID, 1); chk("r2_rdata", RRSP_DATA, 32'h1234_5678);
    chk("r2_err", RRSP_ERR, 0); chk("r2_resp_psel1", M1_PSEL, 0); chk("r2_resp_pen", M_PENABLE, 0);
    nxt(); #1; chk("r2_done", RRSP_VALID, 0);
    M0_PSLVERR = 0;

    // Round-robin from reset with both sides valid
    nxt(); ARESET = 1;
    nxt(); ARESET = 0;
    for (int i = 0; i < 4; i++) begin
      nxt(); WREQ_VALID = 1; RREQ_VALID = 1; WREQ_ADDR = 32'hC000_0100; RREQ_ADDR = 32'hC000_0200;
      #1; chk("rr_wready", WREQ_READY, (i % 2 == 0) ? 1 : 0);
      chk("rr_rready", RREQ_READY, (i % 2 == 0) ? 0 : 1);
      nxt(); WREQ_VALID = 0; RREQ_VALID = 0;
      #1; chk("rr_pwrite", M_PWRITE, (i % 2 == 0) ? 1 : 0);
      repeat (3) nxt();
    end

    // Decode miss on read: no APB activity, response next cycle
    nxt(); RREQ_VALID = 1; RREQ_ADDR = 32'h8000_0000;
    #1; chk("de_rready", RREQ_READY, 1);
    nxt(); RREQ_VALID = 0;
    #1; chk("de_rrsp", RRSP_VALID, 1); chk("de_err", RRSP_ERR, 1); chk("de_data", RRSP_DATA, 0);
    chk("de_psel", {M0_PSEL, M1_PSEL}, 0); chk("de_paddr_hold", M_PADDR, 32'hC000_0200);
    nxt(); #1; chk("de_done", RRSP_VALID, 0);

    // Write just past the slave 1 window
    nxt(); WREQ_VALID = 1; WREQ_ADDR = 32'hC000_2000; WREQ_DATA = 32'h1; WREQ_STRB = 4'h1;
    #1; chk("de2_wready", WREQ_READY, 1);
    nxt(); WREQ_VALID = 0;
    #1; chk("de2_wrsp", WRSP_VALID, 1); chk("de2_err", WRSP_ERR, 1); chk("de2_psel", {M0_PSEL, M1_PSEL}, 0);
    nxt(); #1; chk("de2_done", WRSP_VALID, 0);

    // PSLVERR write with back-pressured response
    M0_PSLVERR = 1; WRSP_READY = 0; RRSP_READY = 0;
    nxt(); WREQ_VALID = 1; WREQ_ADDR = 32'hC000_0040; WREQ_DATA = 32'h0BAD_F00D; WREQ_STRB = 4'h3;
    #1; chk("se_wready", WREQ_READY, 1);
    nxt(); WREQ_VALID = 0;
    #1; chk("se_psel0", M0_PSEL, 1); chk("se_pstrb", M_PSTRB, 4'h3);
    nxt();
    nxt(); WREQ_VALID = 1; RREQ_VALID = 1; RREQ_ADDR = 32'hC000_0050;
    #1; chk("se_wrsp", WRSP_VALID, 1); chk("se_err", WRSP_ERR, 1);
    for (int k = 0; k < 5; k++) begin
      nxt(); #1; chk("se_hold_v", WRSP_VALID, 1); chk("se_hold_err", WRSP_ERR, 1);
      chk("se_no_wready", WREQ_READY, 0); chk("se_no_rready", RREQ_READY, 0); chk("se_hold_psel", M0_PSEL, 0);
    end
    nxt(); WRSP_READY = 1;
    #1; chk("se_take_v", WRSP_VALID, 1); chk("se_take_rready", RREQ_READY, 0);
    nxt(); WREQ_VALID = 0; M0_PSLVERR = 0; M0_PRDATA = 32'hCAFE_0000; RRSP_READY = 1;
    #1; chk("se_after_wrsp", WRSP_VALID, 0); chk("se_after_rready", RREQ_READY, 1);
    nxt(); RREQ_VALID = 0;
    #1; chk("se_rd_psel0", M0_PSEL, 1); chk("se_rd_paddr", M_PADDR, 32'hC000_0050); chk("se_rd_pwrite", M_PWRITE, 0);
    nxt(); #1; chk("se_rd_pen", M_PENABLE, 1);
    nxt(); #1; chk("se_rd_rrsp", RRSP_VALID, 1); chk("se_rd_data", RRSP_DATA, 32'hCAFE_0000); chk("se_rd_err", RRSP_ERR, 0);
    nxt(); #1; chk("se_rd_done", RRSP_VALID, 0);

    // Asynchronous reset in the middle of ACCESS
    M1_PREADY = 0;
    nxt(); RREQ_VALID = 1; RREQ_ADDR = 32'hC000_1008;
    #1; chk("ar_rready", RREQ_READY, 1);
    nxt(); RREQ_VALID = 0;
    nxt(); #1; chk("ar_acc_psel1", M1_PSEL, 1); chk("ar_acc_pen", M_PENABLE, 1);
    #2 ARESET = 1;
    #1; chk("ar_async_psel1", M1_PSEL, 0); chk("ar_async_pen", M_PENABLE, 0);
    nxt(); ARESET = 0; M1_PREADY = 1;
    for (int k = 0; k < 4; k++) begin
      nxt(); #1; chk("ar_no_rrsp", RRSP_VALID, 0); chk("ar_no_psel", M1_PSEL, 0);
    end

`ifdef APB_TIMEOUT_EN
    // Slave 1 never ready: abort after 8 ACCESS cycles
    M1_PREADY = 0;
    nxt(); WREQ_VALID = 1; WREQ_ADDR = 32'hC000_1010; WREQ_DATA = 32'h5; WREQ_STRB = 4'hF;
    #1; chk("to_wready", WREQ_READY, 1);
    nxt(); WREQ_VALID = 0;
    for (int k = 0; k < 8; k++) begin
      nxt(); #1; chk("to_acc_pen", M_PENABLE, 1); chk("to_acc_wrsp", WRSP_VALID, 0);
    end
    nxt(); #1; chk("to_wrsp", WRSP_VALID, 1); chk("to_err", WRSP_ERR, 1);
    chk("to_psel1", M1_PSEL, 0); chk("to_pen", M_PENABLE, 0);
    nxt(); #1; chk("to_done", WRSP_VALID, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
